// File: rtl/tx.sv
// tx: 8-bit UART transmitter, 8N1 framing (start, 8 data bits LSB first, stop).
// Latency: start bit appears on the edge that accepts i_wr. The frame lasts 10*CLKS_PER_BIT cycles (11* with parity).
// Backpressure: o_busy is high for the whole frame. i_wr is ignored while busy and re-accepted on the first idle edge.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_wr       write request, level-sensitive, sampled only while idle
//   i_data     byte to send, captured on the accepting edge
//   o_busy     high while a frame is in progress (flop output)
//   o_uart_tx  serial line, idle high (flop output)
// Optional feature: define TX_PARITY_EN to insert an even-parity bit between
// data bit 7 and the stop bit.
module tx #(
   parameter int CLKS_PER_BIT = 1563,
   parameter int DATA_W       = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_busy,
   output logic              o_uart_tx
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef TX_PARITY_EN
   localparam logic [2:0] ST_PAR   = 3'd4;
`endif

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              bit_end;
`ifdef TX_PARITY_EN
   logic              par_q, par_d;
`endif

   // Last cycle of the current bit period; every bit boundary reloads the counter.
   assign bit_end = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
`ifdef TX_PARITY_EN
      par_d   = par_q;
`endif

      // The counter stays at zero while idle, so an accept always starts a full bit.
      if (state_q != ST_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (i_wr) begin
               state_d = ST_START;
               shift_d = i_data;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
`ifdef TX_PARITY_EN
               par_d   = ^i_data;
`endif
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               idx_d   = '0;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[DATA_W-1:1]};
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (idx_q == IDX_LAST) begin
`ifdef TX_PARITY_EN
                  state_d = ST_PAR;
                  tx_d    = par_q;
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[DATA_W-1:1]};
               end
            end
         end
`ifdef TX_PARITY_EN
         ST_PAR: begin
            if (bit_end) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign o_busy    = busy_q;
   assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_tx.sv
// tb_tx: self-checking bench for the UART transmitter.
// Uses a short bit period so that many frames fit in a short run.
// Expected frames come from a per-row table or from a bit-list model of the framing rules.
module tb_tx;

   localparam int CPB = 5;
`ifdef TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_wr;
   logic [7:0] i_data;
   logic       o_busy;
   logic       o_uart_tx;

   int total = 0;
   int bad   = 0;

   tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr      (i_wr),
      .i_data    (i_data),
      .o_busy    (o_busy),
      .o_uart_tx (o_uart_tx)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   typedef struct {
      logic [7:0] data;
      int         wr_cycles;
      int         churn;
      logic [9:0] frame;  // 8N1 line bits, slot 0 (start) in bit 0
      logic       par;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Line bit per slot from table values.
   function automatic logic [10:0] mk(input logic [9:0] f, input logic p);
`ifdef TX_PARITY_EN
      return {1'b1, p, f[8:0]};
`else
      return {1'b0, f};
`endif
   endfunction

   // Reference framing model: list of line bits in transmit order.
   function automatic logic [10:0] model(input logic [7:0] d);
      bit q[$];
      logic [10:0] r = '0;
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef TX_PARITY_EN
      q.push_back(bit'($countones(d) % 2));
`endif
      q.push_back(1'b1);
      for (int i = 0; i < q.size(); i++) r[i] = q[i];
      return r;
   endfunction

   // The caller raises i_wr before the accepting posedge.
   // churn 1 randomises i_data every cycle, and churn 2 sets it to 0xFF mid-frame.
   // The task returns on the single idle cycle that follows the frame.
   task automatic run_frame(input logic [10:0] exp, input int wr_cycles, input int churn, input string nm);
      int n = 0;
      int errs;
      logic [1:0] act;
      for (int s = 0; s < NB; s++) begin
         errs = 0;
         act  = {1'b1, exp[s]};
         for (int c = 0; c < CPB; c++) begin
            @(negedge i_clk);
            n++;
            if ({o_busy, o_uart_tx} !== {1'b1, exp[s]}) begin
               if (errs == 0) act = {o_busy, o_uart_tx};
               errs++;
            end
            if (n == wr_cycles) i_wr = 1'b0;
            if (churn == 1) i_data = 8'($urandom);
            else if (churn == 2 && n == FRAME / 2) i_data = 8'hFF;
         end
         check(errs == 0, $sformatf("%s slot%0d busy,tx", nm, s), 32'(act), 32'({1'b1, exp[s]}));
      end
      @(negedge i_clk);
      check({o_busy, o_uart_tx} === 2'b01, {nm, " end busy,tx"}, 32'({o_busy, o_uart_tx}), 32'h1);
   endtask

   task automatic idle_check(input int cycles, input string nm);
      int errs = 0;
      logic [1:0] act = 2'b01;
      for (int c = 0; c < cycles; c++) begin
         @(negedge i_clk);
         if ({o_busy, o_uart_tx} !== 2'b01) begin
            if (errs == 0) act = {o_busy, o_uart_tx};
            errs++;
         end
      end
      check(errs == 0, {nm, " idle busy,tx"}, 32'(act), 32'h1);
   endtask

   initial begin
      logic [7:0] d;
      int wc;
      int ch;
      int gap;

      tbl[0] = '{8'h56, 1,         0, 10'b1010101100, 1'b0};
      tbl[1] = '{8'h65, 1,         0, 10'b1011001010, 1'b0};
      tbl[2] = '{8'h07, 1,         1, 10'b1000001110, 1'b1};
      tbl[3] = '{8'h00, 3,         0, 10'b1000000000, 1'b0};
      tbl[4] = '{8'hFF, 1,         1, 10'b1111111110, 1'b0};
      tbl[5] = '{8'hA5, FRAME - 3, 0, 10'b1101001010, 1'b0};

      i_rst_n = 1'b1;
      i_wr    = 1'b0;
      i_data  = 8'h00;
      #2 i_rst_n = 1'b0;
      #1 check({o_busy, o_uart_tx} === 2'b01, "reset busy,tx", 32'({o_busy, o_uart_tx}), 32'h1);
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      idle_check(5, "post_reset");

      // Table-driven frames.
      for (int i = 0; i < 6; i++) begin
         i_data = tbl[i].data;
         i_wr   = 1'b1;
         run_frame(mk(tbl[i].frame, tbl[i].par), tbl[i].wr_cycles, tbl[i].churn,
                   $sformatf("tbl%0d", i));
         idle_check(3, $sformatf("tbl%0d", i));
      end

      // Long strobe ending just before the frame end must not start a second frame.
      i_data = 8'h56;
      i_wr   = 1'b1;
      run_frame(mk(10'b1010101100, 1'b0), FRAME - 3, 0, "long_strobe");
      idle_check(40, "long_strobe");
      i_data = 8'h65;
      i_wr   = 1'b1;
      run_frame(mk(10'b1011001010, 1'b0), 1, 0, "after_long");

      // Data changes to 0xFF mid-frame while i_wr stays high. The frame keeps 0x3C,
      // and 0xFF is taken only after one idle cycle.
      i_data = 8'h3C;
      i_wr   = 1'b1;
      run_frame(mk(10'b1001111000, 1'b0), 1 << 30, 2, "hold_3c");
      run_frame(mk(10'b1111111110, 1'b0), 1, 0, "then_ff");
      idle_check(2, "then_ff");

      // Back-to-back frames with i_wr held high continuously.
      i_wr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         d      = 8'($urandom);
         i_data = d;
         run_frame(model(d), (k == 2) ? 1 : (1 << 30), 0, $sformatf("b2b%0d", k));
      end
      idle_check(2, "b2b");

      // Randomised frames against the model.
      for (int k = 0; k < 10; k++) begin
         d   = 8'($urandom);
         wc  = $urandom_range(FRAME - 1, 1);
         ch  = $urandom_range(1, 0);
         gap = $urandom_range(3, 0);
         repeat (gap) @(negedge i_clk);
         i_data = d;
         i_wr   = 1'b1;
         run_frame(model(d), wc, ch, $sformatf("rnd%0d_%02h", k, d));
      end
      idle_check(3, "rnd");

      // Reset mid-frame: the line goes high at once and the frame does not resume.
      i_data = 8'h5A;
      i_wr   = 1'b1;
      @(negedge i_clk);
      i_wr = 1'b0;
      repeat (CPB + 1) @(negedge i_clk);
      check({o_busy, o_uart_tx} === 2'b10, "mid_frame busy,tx", 32'({o_busy, o_uart_tx}), 32'h2);
      i_rst_n = 1'b0;
      #1 check({o_busy, o_uart_tx} === 2'b01, "async_reset busy,tx", 32'({o_busy, o_uart_tx}), 32'h1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      idle_check(2 * FRAME, "after_abort");
      i_data = 8'h56;
      i_wr   = 1'b1;
      run_frame(mk(10'b1010101100, 1'b0), 1, 0, "after_abort_frame");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
